// File: rtl/mem_loader.sv
// Block loader: accepts SIZE words from a valid/ready producer, then holds the block for a reader until it is released.
// Define MEM_LOADER_CHECKSUM_EN to add a running modulo-2^WIDTH checksum output. The release input is named release_req because release is a reserved word.
//
// state | meaning
// IDLE  | no block held; waits for start
// LOAD  | accepting words into mem[count]
// FULL  | SIZE words held; waits for release_req
module mem_loader #(
  parameter int WIDTH   = 16,
  parameter int SIZE    = 1024,
  parameter int LOGSIZE = $clog2(SIZE)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               loaded,
  input  logic               release_req,
  input  logic [LOGSIZE-1:0] rd_addr,
  output logic [WIDTH-1:0]   rd_data,
  output logic [LOGSIZE:0]   count
`ifdef MEM_LOADER_CHECKSUM_EN
  ,
  output logic [WIDTH-1:0]   checksum
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

  localparam logic [LOGSIZE:0] LAST = (LOGSIZE+1)'(SIZE - 1);

  state_t           state;
  logic [WIDTH-1:0] mem [SIZE];
  logic             take;

  assign take = (state == LOAD) && in_valid && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      in_ready <= 1'b0;
      loaded   <= 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
      checksum <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            in_ready <= 1'b1;
`ifdef MEM_LOADER_CHECKSUM_EN
            checksum <= '0;
`endif
          end
        end
        LOAD: begin
          if (in_valid) begin
            count <= count + 1'b1;
`ifdef MEM_LOADER_CHECKSUM_EN
            checksum <= checksum + in_data;
`endif
            if (count == LAST) begin
              state    <= FULL;
              in_ready <= 1'b0;
              loaded   <= 1'b1;
            end
          end
        end
        FULL: begin
          if (release_req) begin
            state  <= IDLE;
            loaded <= 1'b0;
            count  <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          count    <= '0;
          in_ready <= 1'b0;
          loaded   <= 1'b0;
        end
      endcase
    end
  end

  // Storage is deliberately unreset so a reset mid-load leaves earlier words intact.
  always_ff @(posedge clk) begin
    if (take) mem[count[LOGSIZE-1:0]] <= in_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: full load, bubbles, FULL hold/release, ignored controls, reset mid-load, optional checksum.
module tb_mem_loader;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, release_req;
  logic [15:0] in_data;
  logic [9:0]  rd_addr;
  logic        in_ready, loaded;
  logic [15:0] rd_data;
  logic [10:0] count;
`ifdef MEM_LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  int errors = 0;
  int checks = 0;

  mem_loader #(.WIDTH(16), .SIZE(1024)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .loaded(loaded),
    .release_req(release_req), .rd_addr(rd_addr), .rd_data(rd_data),
    .count(count)
`ifdef MEM_LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; release_req = 1'b0;
    in_data = '0; rd_addr = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++; if (count !== 11'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if (loaded !== 1'b0) begin errors++; $display("FAIL reset_loaded: got %b expected 0", loaded); end
  endtask

  task automatic test_full_load();
    int early = 0;
    start = 1'b1; in_valid = 1'b1; in_data = 16'h0;
    for (int c = 1; c <= 1025; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 1) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL start_latency: in_ready got %b expected 1", in_ready); end
      end
      if (c < 1025 && loaded !== 1'b0) early++;
      in_data = 16'(c - 1);
    end
    checks++; if (early != 0) begin errors++; $display("FAIL loaded_early: loaded high in %0d cycles expected 0", early); end
    checks++; if (loaded !== 1'b1) begin errors++; $display("FAIL loaded_at_1025: got %b expected 1", loaded); end
    checks++; if (count !== 11'd1024) begin errors++; $display("FAIL full_count: got %0d expected 1024", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b expected 0", in_ready); end
    rd_addr = 10'd37; #1;
    checks++; if (rd_data !== 16'd37) begin errors++; $display("FAIL rd_37: got %0d expected 37", rd_data); end
    rd_addr = 10'd1023; #1;
    checks++; if (rd_data !== 16'd1023) begin errors++; $display("FAIL rd_1023: got %0d expected 1023", rd_data); end
  endtask

  task automatic test_full_hold();
    int bad = 0;
    in_valid = 1'b1; in_data = 16'hFFFF;
    repeat (10) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || loaded !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL full_hold: %0d bad cycles expected 0", bad); end
    rd_addr = 10'd0; #1;
    checks++; if (rd_data !== 16'd0) begin errors++; $display("FAIL full_mem0: got %h expected 0000", rd_data); end
    rd_addr = 10'd1023; #1;
    checks++; if (rd_data !== 16'd1023) begin errors++; $display("FAIL full_mem1023: got %h expected 03ff", rd_data); end
    release_req = 1'b1;
    @(negedge clk);
    release_req = 1'b0;
    checks++; if (loaded !== 1'b0) begin errors++; $display("FAIL release_loaded: got %b expected 0", loaded); end
    checks++; if (count !== 11'd0) begin errors++; $display("FAIL release_count: got %0d expected 0", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL release_in_ready: got %b expected 0", in_ready); end
    repeat (3) @(negedge clk);
    checks++; if (count !== 11'd0 || in_ready !== 1'b0) begin errors++; $display("FAIL idle_ignore: count %0d in_ready %b expected 0 0", count, in_ready); end
    rd_addr = 10'd5; #1;
    checks++; if (rd_data !== 16'd5) begin errors++; $display("FAIL idle_mem5: got %h expected 0005", rd_data); end
    in_valid = 1'b0;
  endtask

  task automatic test_bubbles();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; in_data = 16'hA5A5;
    @(negedge clk);
    checks++; if (count !== 11'd1) begin errors++; $display("FAIL bubble_c1: got %0d expected 1", count); end
    in_valid = 1'b0; in_data = 16'hDEAD;
    @(negedge clk);
    checks++; if (count !== 11'd1) begin errors++; $display("FAIL bubble_hold1: got %0d expected 1", count); end
    in_valid = 1'b1; in_data = 16'h1111;
    @(negedge clk);
    checks++; if (count !== 11'd2) begin errors++; $display("FAIL bubble_c2: got %0d expected 2", count); end
    in_valid = 1'b0; in_data = 16'hDEAD;
    @(negedge clk);
    checks++; if (count !== 11'd2) begin errors++; $display("FAIL bubble_hold2: got %0d expected 2", count); end
    rd_addr = 10'd0; #1;
    checks++; if (rd_data !== 16'hA5A5) begin errors++; $display("FAIL bubble_mem0: got %h expected a5a5", rd_data); end
    rd_addr = 10'd1; #1;
    checks++; if (rd_data !== 16'h1111) begin errors++; $display("FAIL bubble_mem1: got %h expected 1111", rd_data); end
    rd_addr = 10'd2; #1;
    checks++; if (rd_data !== 16'h0002) begin errors++; $display("FAIL bubble_mem2: got %h expected 0002", rd_data); end
  endtask

  task automatic test_ignore_controls();
    for (int i = 2; i < 10; i++) begin
      in_valid = 1'b1; in_data = 16'(i);
      @(negedge clk);
    end
    checks++; if (count !== 11'd10) begin errors++; $display("FAIL ign_c10: got %0d expected 10", count); end
    start = 1'b1; release_req = 1'b1; in_data = 16'd10;
    @(negedge clk);
    start = 1'b0; release_req = 1'b0;
    checks++; if (count !== 11'd11 || in_ready !== 1'b1 || loaded !== 1'b0) begin
      errors++; $display("FAIL ign_c11: count %0d in_ready %b loaded %b expected 11 1 0", count, in_ready, loaded);
    end
    in_data = 16'd11;
    @(negedge clk);
    checks++; if (count !== 11'd12) begin errors++; $display("FAIL ign_c12: got %0d expected 12", count); end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_midload();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 500; c++) begin
      in_valid = 1'b1; in_data = 16'h8000 | 16'(c);
      @(negedge clk);
    end
    checks++; if (count !== 11'd500) begin errors++; $display("FAIL mid_c500: got %0d expected 500", count); end
    reset = 1'b1; in_valid = 1'b1; in_data = 16'h7777;
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    checks++; if (count !== 11'd0 || loaded !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL mid_reset: count %0d loaded %b in_ready %b expected 0 0 0", count, loaded, in_ready);
    end
    rd_addr = 10'd0; #1;
    checks++; if (rd_data !== 16'h8000) begin errors++; $display("FAIL mid_mem0: got %h expected 8000", rd_data); end
    rd_addr = 10'd499; #1;
    checks++; if (rd_data !== 16'h81F3) begin errors++; $display("FAIL mid_mem499: got %h expected 81f3", rd_data); end
    rd_addr = 10'd500; #1;
    checks++; if (rd_data !== 16'h01F4) begin errors++; $display("FAIL mid_mem500: got %h expected 01f4", rd_data); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 16'h4242;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (count !== 11'd1) begin errors++; $display("FAIL reload_count: got %0d expected 1", count); end
    rd_addr = 10'd0; #1;
    checks++; if (rd_data !== 16'h4242) begin errors++; $display("FAIL reload_mem0: got %h expected 4242", rd_data); end
    rd_addr = 10'd1; #1;
    checks++; if (rd_data !== 16'h8001) begin errors++; $display("FAIL reload_mem1: got %h expected 8001", rd_data); end
  endtask

`ifdef MEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [15:0] vals [2];
    logic [15:0] exps [2];
    vals[0] = 16'h0040; exps[0] = 16'h0000;
    vals[1] = 16'h0001; exps[1] = 16'h0400;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (checksum !== 16'h0) begin errors++; $display("FAIL csum_reset: got %h expected 0000", checksum); end
    for (int k = 0; k < 2; k++) begin
      start = 1'b1; in_valid = 1'b1; in_data = vals[k];
      repeat (1025) begin
        @(negedge clk);
        start = 1'b0;
      end
      in_valid = 1'b0;
      checks++; if (loaded !== 1'b1 || checksum !== exps[k]) begin
        errors++; $display("FAIL csum_%0d: loaded %b checksum %h expected 1 %h", k, loaded, checksum, exps[k]);
      end
      release_req = 1'b1;
      @(negedge clk);
      release_req = 1'b0;
      checks++; if (checksum !== exps[k]) begin errors++; $display("FAIL csum_hold_%0d: got %h expected %h", k, checksum, exps[k]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_load();
    test_full_hold();
    test_bubbles();
    test_ignore_controls();
    test_reset_midload();
`ifdef MEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
